// File: rtl/instr_mem_responder.sv
// instr_mem_responder: word-addressed instruction memory with fixed-latency, in-order fetch responses and a program-load write port
module instr_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 1,
    parameter int          NUM_REQS  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        instr_rvalid_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]              mem [MEM_WORDS];
    logic [LATENCY-1:0]       pv;
    logic [LATENCY-1:0]       pe;
    logic [LATENCY-1:0][31:0] pd;
    logic [2:0]               outstanding;
    logic                     retiring;
    logic                     fetch_ok;
    logic                     load_ok;
    logic [AW-1:0]            fetch_idx;
    logic [AW-1:0]            load_idx;

    // 33-bit compare so the upper bound cannot wrap past 2^32
    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, a} < ({1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    // grant while a slot is free or one frees up this cycle; outputs are zero unless a response is due
    always_comb begin
        retiring       = pv[LATENCY-1];
        instr_gnt_o    = rstn & instr_req_i & ((outstanding < 3'(NUM_REQS)) | retiring);
        fetch_ok       = in_range(instr_addr_i);
        load_ok        = in_range(load_addr_i);
        fetch_idx      = word_idx(instr_addr_i);
        load_idx       = word_idx(load_addr_i);
        instr_rvalid_o = retiring;
        instr_rdata_o  = retiring ? pd[LATENCY-1] : '0;
        instr_err_o    = retiring & pe[LATENCY-1];
    end

    // array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (load_we_i && load_ok) mem[load_idx] <= load_wdata_i;
    end

    // response pipeline captures the pre-write array word on the grant edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv <= '0;
            pe <= '0;
            pd <= '0;
        end else begin
            pv[0] <= instr_gnt_o;
            pe[0] <= instr_gnt_o & ~fetch_ok;
            pd[0] <= (instr_gnt_o && fetch_ok) ? mem[fetch_idx] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    // granted-but-unanswered count; a grant and a retirement in the same cycle cancel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) outstanding <= '0;
        else       outstanding <= outstanding + 3'(instr_gnt_o) - 3'(retiring);
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: scoreboard bench for a LATENCY=1 and a LATENCY=3 responder sharing one load bus
module tb_instr_mem_responder;
    typedef struct packed {
        logic [31:0] d;
        logic        e;
        logic [31:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn, rstn3;
    logic        req, req3;
    logic [31:0] addr, addr3;
    logic        load_we;
    logic [31:0] load_addr, load_wdata;
    logic        gnt, err, rvalid;
    logic [31:0] rdata;
    logic        gnt3, err3, rvalid3;
    logic [31:0] rdata3;
    logic [31:0] cyc = '0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    exp_t        q3[$];

    instr_mem_responder #(.LATENCY(1), .NUM_REQS(2)) dut (
        .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt), .instr_addr_i(addr),
        .instr_rdata_o(rdata), .instr_err_o(err), .instr_rvalid_o(rvalid),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata)
    );

    instr_mem_responder #(.LATENCY(3), .NUM_REQS(2)) dut3 (
        .clk(clk), .rstn(rstn3), .instr_req_i(req3), .instr_gnt_o(gnt3), .instr_addr_i(addr3),
        .instr_rdata_o(rdata3), .instr_err_o(err3), .instr_rvalid_o(rvalid3),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (rvalid) begin
                if (q.size() == 0) check("dut unexpected rvalid", {31'b0, rvalid}, 32'd0);
                else begin
                    e = q.pop_front();
                    check("dut rdata", rdata, e.d);
                    check("dut err", {31'b0, err}, {31'b0, e.e});
                    check("dut rvalid cycle", cyc, e.c);
                end
            end else begin
                check("dut idle rdata", rdata, 32'd0);
                check("dut idle err", {31'b0, err}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rstn3) begin
            if (rvalid3) begin
                if (q3.size() == 0) check("dut3 unexpected rvalid", {31'b0, rvalid3}, 32'd0);
                else begin
                    e = q3.pop_front();
                    check("dut3 rdata", rdata3, e.d);
                    check("dut3 err", {31'b0, err3}, {31'b0, e.e});
                    check("dut3 rvalid cycle", cyc, e.c);
                end
            end else begin
                check("dut3 idle rdata", rdata3, 32'd0);
                check("dut3 idle err", {31'b0, err3}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_we = 1'b1;
        load_addr = a;
        load_wdata = d;
        step();
        load_we = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
        req = 1'b1;
        addr = a;
        @(negedge clk);
        check("dut gnt", {31'b0, gnt}, 32'd1);
        if (gnt) q.push_back('{d: exp_d, e: exp_e, c: cyc + 1});
        step();
        req = 1'b0;
    endtask

    task automatic fetch3(input logic [31:0] a, input logic exp_g, input logic [31:0] exp_d, input logic exp_e);
        req3 = 1'b1;
        addr3 = a;
        @(negedge clk);
        check("dut3 gnt", {31'b0, gnt3}, {31'b0, exp_g});
        if (gnt3) q3.push_back('{d: exp_d, e: exp_e, c: cyc + 3});
        step();
        req3 = 1'b0;
    endtask

    initial begin
        int n;
        rstn = 1'b1;
        rstn3 = 1'b1;
        req = 1'b0;
        req3 = 1'b0;
        addr = '0;
        addr3 = '0;
        load_we = 1'b0;
        load_addr = '0;
        load_wdata = '0;
        #2;
        rstn = 1'b0;
        rstn3 = 1'b0;
        req = 1'b1;
        req3 = 1'b1;
        @(negedge clk);
        check("reset gnt", {31'b0, gnt}, 32'd0);
        check("reset gnt3", {31'b0, gnt3}, 32'd0);
        check("reset rvalid", {31'b0, rvalid}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset err", {31'b0, err}, 32'd0);
        step();
        req = 1'b0;
        req3 = 1'b0;
        step();
        rstn = 1'b1;
        rstn3 = 1'b1;
        step();
        load(32'h0000_0000, 32'h0000_0013);
        load(32'h0000_0004, 32'h0040_0093);
        load(32'h0000_0008, 32'h1111_1111);
        load(32'h0000_0FF0, 32'hAAAA_5555);
        load(32'h0000_0FFC, 32'hCAFE_F00D);
        fetch(32'h0000_0000, 32'h0000_0013, 1'b0);
        fetch(32'h0000_0004, 32'h0040_0093, 1'b0);
        fetch(32'h0000_0FFC, 32'hCAFE_F00D, 1'b0);
        step();
        fetch(32'h0000_1000, 32'h0000_0000, 1'b1);
        fetch(32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        step();
        load_we = 1'b1;
        load_addr = 32'h0000_0008;
        load_wdata = 32'hDEAD_BEEF;
        fetch(32'h0000_0008, 32'h1111_1111, 1'b0);
        load_we = 1'b0;
        fetch(32'h0000_0008, 32'hDEAD_BEEF, 1'b0);
        fetch(32'h0000_0006, 32'h0040_0093, 1'b0);
        load(32'hFFFF_FFF0, 32'h1234_5678);
        load(32'h0000_1000, 32'h5555_5555);
        fetch(32'h0000_0FF0, 32'hAAAA_5555, 1'b0);
        fetch(32'h0000_0000, 32'h0000_0013, 1'b0);
        fetch(32'hFFFF_FFF0, 32'h0000_0000, 1'b1);
        repeat (4) step();
        fetch3(32'h0000_0000, 1'b1, 32'h0000_0013, 1'b0);
        fetch3(32'h0000_0004, 1'b1, 32'h0040_0093, 1'b0);
        fetch3(32'h0000_0008, 1'b0, 32'hDEAD_BEEF, 1'b0);
        fetch3(32'h0000_0008, 1'b1, 32'hDEAD_BEEF, 1'b0);
        repeat (8) step();
        fetch3(32'h0000_0000, 1'b1, 32'h0000_0013, 1'b0);
        fetch3(32'h0000_0004, 1'b1, 32'h0040_0093, 1'b0);
        rstn3 = 1'b0;
        q3.delete();
        req3 = 1'b1;
        @(negedge clk);
        check("dut3 gnt in reset", {31'b0, gnt3}, 32'd0);
        step();
        req3 = 1'b0;
        rstn3 = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid3) n++;
        end
        check("dut3 rvalid after reset", n, 32'd0);
        step();
        fetch3(32'h0000_0000, 1'b1, 32'h0000_0013, 1'b0);
        fetch3(32'h0000_0004, 1'b1, 32'h0040_0093, 1'b0);
        repeat (8) step();
        check("dut responses pending", q.size(), 32'd0);
        check("dut3 responses pending", q3.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
